// File: rtl/gemm_pkg.sv
// Shared types and default sizes for the GEMM memory sequencer.
package gemm_pkg;
    localparam int NUM_RAMS_DEF = 16;
    localparam int D_WID_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DRAIN,
        DONE
    } state_e;
endpackage

// File: rtl/gemm_mem_sequencer_if.sv
// Command, memory port, read/write streams and status of the sequencer.
interface gemm_mem_sequencer_if #(
    parameter int NUM_RAMS = gemm_pkg::NUM_RAMS_DEF,
    parameter int D_WID    = gemm_pkg::D_WID_DEF
);
    localparam int W = NUM_RAMS * D_WID;

    logic         start;
    logic         mode;
    logic [31:0]  base_addr;
    logic [15:0]  stride;
    logic [7:0]   rows;
    logic [4:0]   width;

    logic         mem_en;
    logic         mem_rdwr;
    logic [4:0]   mem_control;
    logic [31:0]  mem_addr;
    logic [W-1:0] mem_wr_data;
    logic [W-1:0] mem_rd_data;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;

    logic         busy;
    logic         done;
    logic         err;

    modport slave (
        input  start, mode, base_addr, stride, rows, width,
        input  mem_rd_data, out_ready, in_valid, in_data,
        output mem_en, mem_rdwr, mem_control, mem_addr,
        output mem_wr_data, out_valid, out_data, out_last,
        output in_ready, busy, done, err
    );

    modport master (
        output start, mode, base_addr, stride, rows, width,
        output mem_rd_data, out_ready, in_valid, in_data,
        input  mem_en, mem_rdwr, mem_control, mem_addr,
        input  mem_wr_data, out_valid, out_data, out_last,
        input  in_ready, busy, done, err
    );
endinterface

// File: rtl/seq_fifo.sv
// Small circular buffer for read-return rows, with occupancy count.
module seq_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rp_q];

    always_comb begin
        wp_d  = push_i ? inc(wp_q) : wp_q;
        rp_d  = do_pop ? inc(rp_q) : rp_q;
        cnt_d = cnt_q;
        unique case ({push_i, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= din_i;
    end
endmodule

// File: rtl/gemm_mem_sequencer.sv
// Strided row sequencer: streams rows between memory and valid/ready ports.
module gemm_mem_sequencer #(
    parameter int NUM_RAMS   = gemm_pkg::NUM_RAMS_DEF,
    parameter int D_WID      = gemm_pkg::D_WID_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gemm_mem_sequencer_if.slave   bus
);
    import gemm_pkg::*;

    localparam int W  = NUM_RAMS * D_WID;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   stride_q, stride_d;
    logic [7:0]    rem_q, rem_d;
    logic [4:0]    width_q, width_d;
    logic          err_q, err_d;
    logic          infl_q, infl_d;
    logic          last_q, last_d;

    logic [CW-1:0] fcnt;
    logic          fempty;
    logic [W:0]    fhead;
    logic          pop, credit, rd_issue, wr_hs, bad_w;

    // A same-cycle pop frees a slot, so issue can continue at full rate.
    assign pop      = !fempty && bus.out_ready;
    assign credit   = (int'(fcnt) + int'(infl_q) < FIFO_DEPTH) || pop;
    assign rd_issue = (state_q == RD) && (rem_q != '0) && credit;
    assign wr_hs    = (state_q == WR) && bus.in_valid;
    assign bad_w    = (bus.width == '0) || (int'(bus.width) > NUM_RAMS);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        width_d  = width_q;
        err_d    = err_q;
        infl_d   = rd_issue;
        last_d   = rd_issue && (rem_q == 8'd1);
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base_addr;
                    stride_d = bus.stride;
                    rem_d    = bus.rows;
                    width_d  = bus.width;
                    err_d    = bad_w;
                    if (bad_w || bus.rows == '0) state_d = DONE;
                    else state_d = bus.mode ? WR : RD;
                end
            end
            RD: begin
                if (rd_issue) begin
                    addr_d = addr_q + {16'b0, stride_q};
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = DRAIN;
                end
            end
            WR: begin
                if (wr_hs) begin
                    addr_d = addr_q + {16'b0, stride_q};
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = DONE;
                end
            end
            DRAIN: begin
                if (fempty && !infl_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            width_q  <= '0;
            err_q    <= 1'b0;
            infl_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            width_q  <= width_d;
            err_q    <= err_d;
            infl_q   <= infl_d;
            last_q   <= last_d;
        end
    end

    seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (infl_q),
        .din_i   ({last_q, bus.mem_rd_data}),
        .pop_i   (pop),
        .dout_o  (fhead),
        .count_o (fcnt),
        .empty_o (fempty)
    );

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.err         = err_q;
    assign bus.mem_en      = rd_issue || wr_hs;
    assign bus.mem_rdwr    = wr_hs;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_control = width_q;
    assign bus.mem_wr_data = bus.in_data;
    assign bus.in_ready    = (state_q == WR);
    assign bus.out_valid   = !fempty;
    assign bus.out_data    = fhead[W-1:0];
    assign bus.out_last    = !fempty && fhead[W];
endmodule

// File: tb/tb_gemm_mem_sequencer.sv
// Directed bench for gemm_mem_sequencer: vector table plus corner sequences.
module tb_gemm_mem_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gemm_mem_sequencer_if bus ();

    gemm_mem_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        mode;
        logic [31:0] base;
        logic [15:0] stride;
        logic [7:0]  rows;
        logic [4:0]  width;
        int          exp_n;
        logic        exp_err;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a, ~a, a ^ 32'hA5A5A5A5, a + 32'h1};
    endfunction

    // Memory model: read data returns one cycle after a read enable.
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_rdwr)
            bus.mem_rd_data <= pat(bus.mem_addr);
    end

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic m, input logic [31:0] b,
                               input logic [15:0] s, input logic [7:0] r,
                               input logic [4:0] w);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.base_addr = b;
        bus.stride    = s;
        bus.rows      = r;
        bus.width     = w;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int n = 0;
        int beats = 0;
        int dones = 0;
        int first_c = 0;
        int last_c = 0;
        logic fin = 1'b0;
        logic [31:0] la = '0;
        logic [31:0] ea;
        logic [31:0] ba;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        pulse_start(v.mode, v.base, v.stride, v.rows, v.width);
        bus.in_valid = v.mode;
        for (int c = 0; c < 100; c++) begin
            ea = v.base + 32'(n) * {16'b0, v.stride};
            bus.in_data = pat(ea);
            #1;
            if (bus.mem_en) begin
                chk($sformatf("v%0d addr", id), bus.mem_addr, ea);
                chk($sformatf("v%0d ctl", id), bus.mem_control, v.width);
                chk($sformatf("v%0d rdwr", id), bus.mem_rdwr, v.mode);
                if (v.mode)
                    chk($sformatf("v%0d wdat", id), bus.mem_wr_data, pat(ea));
                if (n == 0) first_c = c;
                last_c = c;
                la = bus.mem_addr;
                n++;
            end
            if (bus.out_valid && bus.out_ready) begin
                ba = v.base + 32'(beats) * {16'b0, v.stride};
                chk($sformatf("v%0d rdat", id), bus.out_data, pat(ba));
                chk($sformatf("v%0d last", id), bus.out_last,
                    beats == int'(v.rows) - 1);
                beats++;
            end
            if (bus.done) begin
                dones++;
                chk($sformatf("v%0d err", id), bus.err, v.exp_err);
            end
            if (dones > 0 && !bus.done) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk($sformatf("v%0d timeout", id), fin, 1'b1);
        chk($sformatf("v%0d n_acc", id), n, v.exp_n);
        chk($sformatf("v%0d n_done", id), dones, 1);
        chk($sformatf("v%0d busy", id), bus.busy, 1'b0);
        chk($sformatf("v%0d beats", id), beats, v.mode ? 0 : v.exp_n);
        if (v.exp_n > 0) begin
            chk($sformatf("v%0d lastaddr", id), la, v.exp_last);
            chk($sformatf("v%0d b2b", id), last_c - first_c, n - 1);
        end
    endtask

    initial begin
        int n;
        int beats;
        int hs;
        int hs_c;
        int done_c;
        logic fin;

        vecs[0] = '{1'b0, 32'h100, 16'd16, 8'd4, 5'd16, 4, 1'b0, 32'h130};
        vecs[1] = '{1'b0, 32'h100, 16'd16, 8'd3, 5'd0, 0, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 32'h40, 16'd8, 8'd3, 5'd8, 3, 1'b0, 32'h50};
        vecs[3] = '{1'b0, 32'hFFFFFFF0, 16'd32, 8'd2, 5'd4, 2, 1'b0, 32'h10};
        vecs[4] = '{1'b0, 32'h80, 16'd4, 8'd0, 5'd4, 0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h80, 16'd4, 8'd1, 5'd17, 0, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'h7, 16'd1, 8'd1, 5'd1, 1, 1'b0, 32'h7};

        bus.start       = 1'b0;
        bus.mode        = 1'b0;
        bus.base_addr   = '0;
        bus.stride      = '0;
        bus.rows        = '0;
        bus.width       = '0;
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.mem_rd_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst err", bus.err, 1'b0);
        chk("rst oval", bus.out_valid, 1'b0);
        chk("rst mem_en", bus.mem_en, 1'b0);
        chk("rst in_rdy", bus.in_ready, 1'b0);
        chk("rst addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Stalled read: credit limit caps issue at two rows.
        bus.out_ready = 1'b0;
        pulse_start(1'b0, 32'h200, 16'd16, 8'd3, 5'd16);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            bus.start = (c == 4);
            bus.mode  = 1'b1;
            #1;
            if (bus.mem_en) n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("stall n_rd", n, 2);
        chk("stall oval", bus.out_valid, 1'b1);
        chk("stall head", bus.out_data, pat(32'h200));
        chk("stall last", bus.out_last, 1'b0);
        bus.out_ready = 1'b1;
        beats = 0;
        fin = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.mem_en) begin
                chk("stall addr3", bus.mem_addr, 32'h220);
                n++;
            end
            if (bus.out_valid) begin
                chk("stall data", bus.out_data,
                    pat(32'h200 + 32'(beats) * 32'd16));
                chk("stall olast", bus.out_last, beats == 2);
                beats++;
            end
            if (bus.done) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("stall done", fin, 1'b1);
        chk("stall n_tot", n, 3);
        chk("stall beats", beats, 3);
        @(negedge clk);

        // Write with toggling in_valid and a wrapping 16-bit stride.
        pulse_start(1'b1, 32'h3, 16'hFFFF, 8'd2, 5'd5);
        hs = 0;
        hs_c = -10;
        done_c = -1;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = c[0];
            bus.in_data  = pat(32'(c));
            #1;
            if (hs < 2) begin
                chk("wr in_rdy", bus.in_ready, 1'b1);
                chk("wr mem_en", bus.mem_en, bus.in_valid);
            end
            if (bus.mem_en) begin
                chk("wr addr", bus.mem_addr, hs == 0 ? 32'h3 : 32'h10002);
                chk("wr ctl", bus.mem_control, 5'd5);
                chk("wr rdwr", bus.mem_rdwr, 1'b1);
                chk("wr data", bus.mem_wr_data, pat(32'(c)));
                hs++;
                hs_c = c;
            end
            if (bus.done) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("wr n_hs", hs, 2);
        chk("wr done_lat", done_c - hs_c, 1);
        @(negedge clk);
        chk("wr idle rdy", bus.in_ready, 1'b0);

        // Reset while the read buffer is full.
        bus.out_ready = 1'b0;
        pulse_start(1'b0, 32'h300, 16'd16, 8'd5, 5'd16);
        repeat (5) @(negedge clk);
        chk("pre-rst oval", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", bus.busy, 1'b0);
        chk("arst oval", bus.out_valid, 1'b0);
        chk("arst olast", bus.out_last, 1'b0);
        chk("arst mem_en", bus.mem_en, 1'b0);
        chk("arst addr", bus.mem_addr, 32'h0);
        chk("arst ctl", bus.mem_control, 5'd0);
        n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        chk("arst no_done", n, 0);
        rst_n = 1'b1;
        run_vec(vecs[0], 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
